// File: rtl/sha256_padder_if.sv
// Stream interface for the SHA-256 padder:
// a 32-bit word input stream and a 512-bit block output stream.
interface sha256_padder_if;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] M_out;
  logic         M_valid;
  logic         M_ready;
  logic         M_last;

  // Padder side
  modport slave (
    input  in_data, in_valid, in_last, in_bytes, M_ready,
    output in_ready, M_out, M_valid, M_last
  );

  // Source / consumer side
  modport master (
    output in_data, in_valid, in_last, in_bytes, M_ready,
    input  in_ready, M_out, M_valid, M_last
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length, and flags the
// final block of each message.
module sha256_padder #(
  parameter int LEN_WIDTH = 64
) (
  input logic           clk,
  input logic           rst,   // asynchronous, active low
  sha256_padder_if.slave bus
);

  typedef enum logic [1:0] {S_ACCEPT, S_PAD, S_LEN, S_EMIT} state_t;

  state_t                state_q, state_d;
  state_t                ret_q, ret_d;     // state to resume after a non-final block
  logic [4:0]            idx_q, idx_d;     // next word slot, 0..16
  logic [LEN_WIDTH-1:0]  len_q, len_d;     // message bit count
  logic                  pend80_q, pend80_d; // 0x80 marker still to be written
  logic                  last_q, last_d;   // block being emitted is the final one
  logic [15:0][31:0]     buf_q;            // buf_q[0] is word 0 of the block

  logic                  wr_en;
  logic [3:0]            wr_sel;
  logic [31:0]           wr_data;
  logic                  clr;
  logic [4:0]            idx_inc;
  logic [2:0]            nb;
  logic [31:0]           last_word;
  logic [63:0]           len64;
  logic [511:0]          m_out;
  logic                  in_ready, m_valid, m_last;

  assign idx_inc = idx_q + 5'd1;
  assign nb      = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
  assign len64   = 64'(len_q);

  // Final word: keep the valid bytes, place the 0x80 marker, zero the rest
  always_comb begin
    last_word = bus.in_data;
    case (nb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    last_word = {bus.in_data[31:8],  8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  // State register and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ACCEPT;
      ret_q    <= S_ACCEPT;
      idx_q    <= '0;
      len_q    <= '0;
      pend80_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      pend80_q <= pend80_d;
      last_q   <= last_d;
    end
  end

  // Next-state, buffer write port and handshake outputs
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    idx_d    = idx_q;
    len_d    = len_q;
    pend80_d = pend80_q;
    last_d   = last_q;
    wr_en    = 1'b0;
    wr_sel   = idx_q[3:0];
    wr_data  = '0;
    clr      = 1'b0;
    in_ready = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    case (state_q)
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          idx_d = idx_inc;
          if (!bus.in_last) begin
            wr_data = bus.in_data;
            len_d   = len_q + LEN_WIDTH'(32);
            if (idx_inc == 5'd16) begin
              state_d = S_EMIT;
              ret_d   = S_ACCEPT;
              last_d  = 1'b0;
            end
          end else begin
            wr_data = last_word;
            if (nb == 3'd4) begin
              len_d    = len_q + LEN_WIDTH'(32);
              pend80_d = 1'b1;
            end else begin
              len_d = len_q + LEN_WIDTH'({nb, 3'b000});
            end
            // Marker already placed and slot 14 reached: straight to length
            if (idx_inc == 5'd16) begin
              state_d = S_EMIT;
              ret_d   = S_PAD;
              last_d  = 1'b0;
            end else if (idx_inc == 5'd14 && nb != 3'd4) begin
              state_d = S_LEN;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        wr_en    = 1'b1;
        wr_data  = pend80_q ? 32'h8000_0000 : 32'h0;
        pend80_d = 1'b0;
        idx_d    = idx_inc;
        if (idx_inc == 5'd16) begin
          state_d = S_EMIT;
          ret_d   = S_PAD;
          last_d  = 1'b0;
        end else if (idx_inc == 5'd14) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        // slot 14 gets the upper half, slot 15 the lower half
        wr_en   = 1'b1;
        wr_data = idx_q[0] ? len64[31:0] : len64[63:32];
        idx_d   = idx_inc;
        if (idx_q[0]) begin
          state_d = S_EMIT;
          ret_d   = S_ACCEPT;
          last_d  = 1'b1;
        end
      end
      S_EMIT: begin
        m_valid = 1'b1;
        m_last  = last_q;
        if (bus.M_ready) begin
          clr   = 1'b1;
          idx_d = '0;
          if (last_q) begin
            len_d   = '0;
            last_d  = 1'b0;
            state_d = S_ACCEPT;
          end else begin
            state_d = ret_q;
          end
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  // Word buffer: one write per cycle, cleared after each block leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       buf_q <= '0;
    else if (clr)   buf_q <= '0;
    else if (wr_en) buf_q[wr_sel] <= wr_data;
  end

  // Word 0 sits in the most significant slice of the output block
  always_comb begin
    m_out = '0;
    for (int i = 0; i < 16; i++) m_out[511-32*i -: 32] = buf_q[i];
  end

  assign bus.in_ready = in_ready;
  assign bus.M_valid  = m_valid;
  assign bus.M_last   = m_last;
  assign bus.M_out    = m_out;

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: expected blocks are queued as messages
// are issued; a monitor pops and compares on every block handshake.
module tb_sha256_padder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_padder_if ifc();

  sha256_padder #(.LEN_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0][31:0] w;
  logic [511:0] sv_out;
  logic         sv_last;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0][31:0] words, input logic last);
    exp_t e;
    e.blk = '0;
    for (int i = 0; i < 16; i++) e.blk[511-32*i -: 32] = words[i];
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Starts and ends just after a rising edge
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    ifc.in_data  = d;
    ifc.in_valid = 1'b1;
    ifc.in_last  = last;
    ifc.in_bytes = nb;
    t = 0;
    @(negedge clk);
    while (!ifc.in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout act=in_ready_low exp=in_ready_high");
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin @(posedge clk); t++; end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_mvalid(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!ifc.M_valid && t < 100) begin @(negedge clk); t++; end
    chk(name, ifc.M_valid, 1'b1);
  endtask

  // Monitor: compare each block as it is handed over
  always @(negedge clk) begin
    if (rst && ifc.M_valid && ifc.M_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_block act=%0h exp=none", ifc.M_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("block", ifc.M_out, e.blk);
        chk("block_last", ifc.M_last, e.last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_data = '0; ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
    ifc.in_bytes = '0; ifc.M_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1'b1);
    chk("rst_m_valid", ifc.M_valid, 1'b0);
    chk("rst_m_last", ifc.M_last, 1'b0);
    chk("rst_m_out", ifc.M_out, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Empty message
    w = '0; w[0] = 32'h8000_0000; push_exp(w, 1'b1);
    send_word(32'h0, 1'b1, 3'd0, 0);
    wait_drain("drain_empty");

    // "abc"
    w = '0; w[0] = 32'h6162_6380; w[15] = 32'h18; push_exp(w, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3, 0);
    wait_drain("drain_abc");

    // 56 bytes: marker spills the length into a second block
    w = '0;
    for (int i = 0; i < 14; i++) w[i] = 32'hA500_0000 | i;
    w[14] = 32'h8000_0000; push_exp(w, 1'b0);
    w = '0; w[15] = 32'h1C0; push_exp(w, 1'b1);
    for (int i = 0; i < 14; i++) send_word(32'hA500_0000 | i, i == 13, 3'd4, 0);
    wait_drain("drain_56");

    // 64 bytes: data-only block then a padding block
    w = '0;
    for (int i = 0; i < 16; i++) w[i] = 32'h5A00_0000 | (i << 8);
    push_exp(w, 1'b0);
    w = '0; w[0] = 32'h8000_0000; w[15] = 32'h200; push_exp(w, 1'b1);
    for (int i = 0; i < 16; i++) send_word(32'h5A00_0000 | (i << 8), i == 15, 3'd4, 0);
    wait_drain("drain_64");

    // 55 bytes: marker lands in word 13, length fits in the same block
    w = '0;
    for (int i = 0; i < 13; i++) w[i] = 32'h3C00_0000 | i;
    w[13] = 32'hAABB_CC80; w[15] = 32'h1B8; push_exp(w, 1'b1);
    for (int i = 0; i < 13; i++) send_word(32'h3C00_0000 | i, 1'b0, 3'd0, 0);
    send_word(32'hAABB_CCDD, 1'b1, 3'd3, 0);
    wait_drain("drain_55");

    // in_bytes above 4 behaves as 4
    w = '0; w[0] = 32'h0102_0304; w[1] = 32'h8000_0000; w[15] = 32'h20; push_exp(w, 1'b1);
    send_word(32'h0102_0304, 1'b1, 3'd7, 0);
    wait_drain("drain_nb7");

    // Backpressure: block held, input stalled
    ifc.M_ready = 1'b0;
    w = '0; w[0] = 32'h6162_6380; w[15] = 32'h18; push_exp(w, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3, 0);
    wait_mvalid("stall_mvalid");
    sv_out = ifc.M_out;
    sv_last = ifc.M_last;
    chk("stall_word0", sv_out[511:480], 32'h6162_6380);
    ifc.in_data = 32'hDEAD_BEEF; ifc.in_valid = 1'b1; ifc.in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out", ifc.M_out, sv_out);
      chk("stall_last", ifc.M_last, sv_last);
      chk("stall_in_ready", ifc.in_ready, 1'b0);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.M_ready = 1'b1;
    wait_drain("drain_stall");

    // Back-to-back messages with random gaps
    w = '0; w[0] = 32'h1122_3344; w[1] = 32'h5580_0000; w[15] = 32'h28; push_exp(w, 1'b1);
    w = '0; w[0] = 32'hDEAD_BEEF; w[1] = 32'hCAFE_F00D; w[2] = 32'h0123_4567;
    w[3] = 32'h8000_0000; w[15] = 32'h60; push_exp(w, 1'b1);
    send_word(32'h1122_3344, 1'b0, 3'd0, $urandom_range(0, 3));
    send_word(32'h5566_7788, 1'b1, 3'd1, $urandom_range(0, 3));
    send_word(32'hDEAD_BEEF, 1'b0, 3'd0, $urandom_range(0, 3));
    send_word(32'hCAFE_F00D, 1'b0, 3'd0, $urandom_range(0, 3));
    send_word(32'h0123_4567, 1'b1, 3'd4, $urandom_range(0, 3));
    wait_drain("drain_b2b");

    // Reset during padding
    send_word(32'h1234_5678, 1'b1, 3'd2, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstpad_m_valid", ifc.M_valid, 1'b0);
    chk("rstpad_in_ready", ifc.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset while a block is waiting
    ifc.M_ready = 1'b0;
    send_word(32'h7777_7777, 1'b0, 3'd0, 0);
    send_word(32'h8888_8888, 1'b1, 3'd1, 0);
    wait_mvalid("rstemit_mvalid_before");
    rst = 1'b0;
    #1;
    chk("rstemit_m_valid", ifc.M_valid, 1'b0);
    chk("rstemit_in_ready", ifc.in_ready, 1'b1);
    chk("rstemit_m_out", ifc.M_out, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    ifc.M_ready = 1'b1;

    // Fresh "abc" carries no residue
    w = '0; w[0] = 32'h6162_6380; w[15] = 32'h18; push_exp(w, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3, 0);
    wait_drain("drain_abc_after_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
